block_scheduler: RTL
====================

Name: block_scheduler

Overview:
Per-core control FSM that receives one block assignment (start pulse, block ID, thread count) from the GPU dispatcher. It sequences the core's threads through fetch/decode/request/wait/execute/update until a RET retires, then returns a one-cycle done pulse. It owns the core PC, the active-thread mask and the handshakes to the fetcher and LSUs. One instance per core; start/done connect to one bit of the dispatcher's core_start/core_done.

Parameters:
THREADS_PER_BLOCK, 4, threads per core/block (power of two, >=1)
PC_WIDTH, 8, program counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle block-start pulse from dispatcher
block_id  input  8  block index, sampled with start
thread_count  input  $clog2(THREADS_PER_BLOCK)+1  active threads in block, sampled with start
fetch_ready  input  1  fetcher has instruction available
instr_ret  input  1  decoded instruction is RET (valid in UPDATE)
lsu_busy  input  THREADS_PER_BLOCK  per-thread LSU outstanding
next_pc  input  THREADS_PER_BLOCK x PC_WIDTH  per-thread computed next PC
fetch_req  output  1  request instruction at current_pc
mem_req  output  1  one-cycle LSU launch strobe
current_pc  output  PC_WIDTH  shared block PC
thread_enable  output  THREADS_PER_BLOCK  active-thread mask
block_id_q  output  8  latched block ID
core_state  output  3  encoded FSM state
done  output  1  one-cycle block-complete pulse

Behaviour:
- Reset (async, reset low): state IDLE, current_pc 0, thread_enable 0, block_id_q 0, fetch_req 0, mem_req 0, done 0. Reset mid-operation aborts the block; no done pulse.
- States/encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7. All outputs are registered or decoded from state only.
- IDLE: on start=1, latch block_id -> block_id_q, current_pc <= 0, thread_enable <= (1<<min(thread_count,THREADS_PER_BLOCK))-1. Values above THREADS_PER_BLOCK clamp to a full mask. thread_count=0 -> go to DONE directly; else go to FETCH.
- start outside IDLE is ignored; block_id and thread_count are don't-care outside IDLE.
- FETCH: fetch_req=1; stay until fetch_ready=1, then go to DECODE.
- DECODE: one cycle, then REQUEST.
- REQUEST: mem_req=1 for exactly this cycle, then WAIT.
- WAIT: stay while |(lsu_busy & thread_enable). Disabled threads' lsu_busy is ignored. Then go to EXECUTE.
- EXECUTE: one cycle, then UPDATE.
- UPDATE: if instr_ret, go to DONE. Else current_pc <= next_pc[lowest enabled thread] (uniform control flow, no divergence) and go to FETCH.
- DONE: done=1 for exactly one cycle. thread_enable <= 0. Go to IDLE unconditionally; a start in that cycle is not accepted.
- Minimum instruction latency: 6 cycles (fetch_ready high, LSUs idle).
- Single-RET block: done high in the cycle after the 6th edge following the edge that samples start.
- PC wraps modulo 2^PC_WIDTH and does not saturate.

Decomposition:
- gpu_pkg: sched_state_t enum (8 states above), THREADS_PER_BLOCK default constant, PC_WIDTH constant, shared with dispatcher and fetcher.
- One sub-module: thread_mask_gen (combinational count -> clamped enable mask, plus lowest-enabled-index encoder). FSM and registers stay in block_scheduler.

Test Plan:
- Reset then start with block_id=5, thread_count=4, fetch_ready=1, lsu_busy=0, instr_ret=1 -> block_id_q=5, thread_enable=4'b1111, states 1..7 in order, single done pulse 6 edges after start edge, then IDLE.
- thread_count=3 with lsu_busy=4'b1000 held -> thread_enable=4'b0111; WAIT passes in 1 cycle (disabled thread ignored).
- Three-instruction program: next_pc=1 then 2, RET on 3rd UPDATE -> current_pc 0->1->2; done after 18 cycles; exactly 3 mem_req pulses.
- fetch_ready low 5 cycles in FETCH and lsu_busy[0] high 4 cycles in WAIT -> FETCH held 6 cycles and WAIT held 5 cycles; fetch_req high throughout FETCH.
- thread_count=0 -> DONE next cycle, done one pulse, no fetch_req/mem_req. Second start pulse mid-block -> ignored, block_id_q unchanged.
- reset low during WAIT -> all outputs return to reset values immediately; no done pulse. New start after release behaves as the first scenario.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: constants and the scheduler state encoding shared by the
// dispatcher, fetcher and per-core block scheduler.
package gpu_pkg;

  localparam int unsigned GPU_THREADS_PER_BLOCK = 4;
  localparam int unsigned GPU_PC_WIDTH          = 8;
  localparam int unsigned BLOCK_ID_WIDTH        = 8;

  // Encoding is visible on core_state, so values are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } sched_state_t;

endpackage

// File: rtl/thread_mask_gen.sv
// thread_mask_gen: combinational helper for the block scheduler.
//   count_i    : requested active-thread count (may exceed THREADS_PER_BLOCK)
//   en_i       : current active-thread mask
//   mask_c_o   : contiguous enable mask for count_i, clamped to full
//   lowest_c_o : index of the lowest set bit of en_i (0 when en_i is empty)
module thread_mask_gen #(
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic [$clog2(THREADS_PER_BLOCK):0]                        count_i,
  input  logic [THREADS_PER_BLOCK-1:0]                              en_i,
  output logic [THREADS_PER_BLOCK-1:0]                              mask_c_o,
  output logic [((THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1)-1:0] lowest_c_o
);

  localparam int unsigned CNT_W = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int unsigned IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;

  // Thread i is enabled when i < count; counts beyond the block size
  // naturally saturate to an all-ones mask.
  always_comb begin
    mask_c_o = '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      mask_c_o[i] = (CNT_W'(i) < count_i);
    end
  end

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    lowest_c_o = '0;
    for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
      if (en_i[i]) begin
        lowest_c_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// block_scheduler: per-core control FSM. Accepts one block from the
// dispatcher, steps the core through fetch/decode/request/wait/execute/update
// per instruction until RET retires, then pulses done for one cycle.
//   clk, reset      : clock, asynchronous active-low reset
//   start           : block-start pulse (honoured only in IDLE)
//   block_id        : block index, sampled with start
//   thread_count    : active threads in block, sampled with start
//   fetch_ready     : fetcher has the instruction at current_pc
//   instr_ret       : current instruction is RET (looked at in UPDATE)
//   lsu_busy        : per-thread LSU outstanding
//   next_pc         : per-thread next PC, thread t at [t*PC_WIDTH +: PC_WIDTH]
//   fetch_req       : high throughout FETCH
//   mem_req         : one-cycle LSU launch strobe (REQUEST)
//   current_pc      : shared block PC
//   thread_enable   : active-thread mask
//   block_id_q      : latched block ID
//   core_state      : encoded FSM state
//   done            : one-cycle block-complete pulse
module block_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = GPU_THREADS_PER_BLOCK,
  parameter int unsigned PC_WIDTH          = GPU_PC_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [BLOCK_ID_WIDTH-1:0]              block_id,
  input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
  input  logic                                   fetch_ready,
  input  logic                                   instr_ret,
  input  logic [THREADS_PER_BLOCK-1:0]           lsu_busy,
  input  logic [THREADS_PER_BLOCK*PC_WIDTH-1:0]  next_pc,
  output logic                                   fetch_req,
  output logic                                   mem_req,
  output logic [PC_WIDTH-1:0]                    current_pc,
  output logic [THREADS_PER_BLOCK-1:0]           thread_enable,
  output logic [BLOCK_ID_WIDTH-1:0]              block_id_q,
  output logic [2:0]                             core_state,
  output logic                                   done
);

  localparam int unsigned IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;

  sched_state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]           pc_q, pc_d;
  logic [THREADS_PER_BLOCK-1:0]  mask_q, mask_d;
  logic [BLOCK_ID_WIDTH-1:0]     bid_q, bid_d;

  logic [THREADS_PER_BLOCK-1:0]  start_mask;
  logic [IDX_W-1:0]              lowest_idx;
  logic [PC_WIDTH-1:0]           pc_sel;

  thread_mask_gen #(
    .THREADS_PER_BLOCK (THREADS_PER_BLOCK)
  ) u_mask_gen (
    .count_i    (thread_count),
    .en_i       (mask_q),
    .mask_c_o   (start_mask),
    .lowest_c_o (lowest_idx)
  );

  // Control flow is uniform, so the lowest enabled thread speaks for the block.
  always_comb begin
    pc_sel = '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (lowest_idx == IDX_W'(i)) begin
        pc_sel = next_pc[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      bid_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      bid_q   <= bid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    bid_d   = bid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bid_d   = block_id;
          pc_d    = '0;
          mask_d  = start_mask;
          state_d = (thread_count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_ready) state_d = ST_DECODE;
      end
      ST_DECODE:  state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT;
      ST_WAIT: begin
        // Only enabled threads can hold the block in WAIT.
        if (!(|(lsu_busy & mask_q))) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (instr_ret) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_sel;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are either register copies or decoded from the state register.
  assign fetch_req     = (state_q == ST_FETCH);
  assign mem_req       = (state_q == ST_REQUEST);
  assign done          = (state_q == ST_DONE);
  assign core_state    = state_q;
  assign current_pc    = pc_q;
  assign thread_enable = mask_q;
  assign block_id_q    = bid_q;

endmodule
